// File: rtl/eth_rgmii_rxbytes.sv
// RGMII receive byte extractor: strips preamble/SFD, emits payload bytes with
// end-of-frame/error strobes, and tracks in-band link status during idle.
module eth_rgmii_rxbytes #(
   parameter int MAX_LEN = 1518,
   parameter int LW      = 12
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_d0,
   input  logic [3:0] i_d1,
   input  logic [1:0] i_ctl,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_eop,
   output logic       o_err,
   output logic       o_link,
   output logic [1:0] o_speed,
   output logic       o_duplex
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_PREAMBLE = 2'd1;
   localparam logic [1:0] S_DATA     = 2'd2;
   localparam logic [1:0] S_DROP     = 2'd3;

   localparam logic [LW-1:0] LEN_LIMIT = LW'(MAX_LEN);
   localparam logic [LW-1:0] CNT_MAX   = '1;

   logic [1:0]    r_state;
   logic [1:0]    w_nextState;
   logic [LW-1:0] r_count;
   logic [LW-1:0] w_nextCount;
   logic [LW-1:0] w_countInc;
   logic          r_frameErr;
   logic          w_nextFrameErr;
   logic          w_dv;
   logic          w_er;
   logic [7:0]    w_byte;
   logic          w_emit;
   logic          w_eop;
   logic          w_eopErr;
   logic          w_statusUpd;

   assign w_dv   = i_ctl[0];
   assign w_er   = i_ctl[0] ^ i_ctl[1];
   assign w_byte = {i_d1, i_d0};

   // Status nibbles are only trusted on clean idle cycles; carrier extension is ignored.
   assign w_statusUpd = (r_state == S_IDLE) && !w_dv && !w_er && (i_d0 == i_d1);

   assign w_countInc = (r_count == CNT_MAX) ? r_count : r_count + LW'(1);

   always_comb begin
      w_nextState    = r_state;
      w_nextCount    = r_count;
      w_nextFrameErr = r_frameErr;
      w_emit         = 1'b0;
      w_eop          = 1'b0;
      w_eopErr       = 1'b0;
      case (r_state)
         S_IDLE, S_PREAMBLE: begin
            if (w_dv) begin
               if (w_er) begin
                  w_nextState = S_DROP;
               end else if (w_byte == 8'h55) begin
                  w_nextState = S_PREAMBLE;
               end else if (w_byte == 8'hD5) begin
                  w_nextState    = S_DATA;
                  w_nextCount    = '0;
                  w_nextFrameErr = 1'b0;
               end else begin
                  w_nextState = S_DROP;
               end
            end else if (r_state == S_PREAMBLE) begin
               w_nextState = S_IDLE;
            end
         end
         S_DATA: begin
            if (w_dv) begin
               w_nextCount = w_countInc;
               if (w_countInc <= LEN_LIMIT) begin
                  w_emit = 1'b1;
               end else begin
                  w_nextFrameErr = 1'b1;
               end
               if (w_er) begin
                  w_nextFrameErr = 1'b1;
               end
            end else begin
               // An SFD followed directly by DV low is a runt and always flagged.
               w_nextState    = S_IDLE;
               w_eop          = 1'b1;
               w_eopErr       = r_frameErr | (r_count == '0);
               w_nextCount    = '0;
               w_nextFrameErr = 1'b0;
            end
         end
         S_DROP: begin
            if (!w_dv) begin
               w_nextState = S_IDLE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_frameErr <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_count    <= w_nextCount;
         r_frameErr <= w_nextFrameErr;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_valid <= 1'b0;
         o_data  <= 8'h00;
         o_eop   <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         o_valid <= w_emit;
         o_eop   <= w_eop;
         o_err   <= w_eopErr;
         if (w_emit) begin
            o_data <= w_byte;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_link   <= 1'b0;
         o_speed  <= 2'b00;
         o_duplex <= 1'b0;
      end else if (w_statusUpd) begin
         o_link   <= i_d0[0];
         o_speed  <= i_d0[2:1];
         o_duplex <= i_d0[3];
      end
   end

endmodule

// File: tb/tb_eth_rgmii_rxbytes.sv
// Scoreboard bench for eth_rgmii_rxbytes: a frame-level reference model queues
// expected bytes/end-of-frame events, and a monitor pops them as the DUT strobes.
module tb_eth_rgmii_rxbytes;

   localparam int MAX_LEN = 100;
   localparam int LW      = 7;

   typedef struct packed {
      logic       isEop;
      logic [7:0] data;
      logic       err;
   } expT;

   logic       i_clk   = 1'b0;
   logic       i_reset = 1'b0;
   logic [3:0] i_d0    = 4'h0;
   logic [3:0] i_d1    = 4'h0;
   logic [1:0] i_ctl   = 2'b00;
   logic       o_valid;
   logic [7:0] o_data;
   logic       o_eop;
   logic       o_err;
   logic       o_link;
   logic [1:0] o_speed;
   logic       o_duplex;

   expT        expQ[$];
   logic [7:0] frameBytes[$];
   logic       frameEr[$];
   int         checks = 0;
   int         fails  = 0;
   logic       modelLink   = 1'b0;
   logic [1:0] modelSpeed  = 2'b00;
   logic       modelDuplex = 1'b0;
   bit         firstGap    = 1'b0;

   always #5 i_clk = ~i_clk;

   eth_rgmii_rxbytes #(.MAX_LEN(MAX_LEN), .LW(LW)) dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_d0     (i_d0),
      .i_d1     (i_d1),
      .i_ctl    (i_ctl),
      .o_valid  (o_valid),
      .o_data   (o_data),
      .o_eop    (o_eop),
      .o_err    (o_err),
      .o_link   (o_link),
      .o_speed  (o_speed),
      .o_duplex (o_duplex)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Inputs change just after a rising edge and are held for one full cycle.
   task automatic applyStimulus(input logic dv, input logic er, input logic [7:0] b);
      i_ctl = {dv ^ er, dv};
      i_d0  = b[3:0];
      i_d1  = b[7:4];
      @(posedge i_clk);
      #1;
   endtask

   task automatic idleCycle(input logic er, input logic [3:0] d0, input logic [3:0] d1);
      applyStimulus(1'b0, er, {d1, d0});
      if (!firstGap && !er && (d0 == d1)) begin
         modelLink   = d0[0];
         modelSpeed  = d0[2:1];
         modelDuplex = d0[3];
      end
      firstGap = 1'b0;
   endtask

   task automatic idleGap(input int n);
      logic [3:0] d0;
      logic [3:0] d1;
      logic       er;
      for (int i = 0; i < n; i++) begin
         er = ($urandom_range(0, 3) == 0);
         d0 = 4'($urandom);
         d1 = ($urandom_range(0, 1) == 1) ? d0 : 4'($urandom);
         idleCycle(er, d0, d1);
      end
   endtask

   task automatic checkStatus();
      checkOutput("status", {o_link, o_speed, o_duplex}, {modelLink, modelSpeed, modelDuplex});
   endtask

   // Leading clean 55s, then a clean D5, then everything up to DV low is payload.
   task automatic predictFrame();
      int   i = 0;
      int   n;
      logic err;
      while (i < frameBytes.size() && frameBytes[i] == 8'h55 && !frameEr[i]) i++;
      if (i >= frameBytes.size() || frameBytes[i] != 8'hD5 || frameEr[i]) return;
      n   = frameBytes.size() - i - 1;
      err = (n == 0) || (n > MAX_LEN);
      for (int j = 0; j < n; j++) begin
         if (frameEr[i + 1 + j]) err = 1'b1;
         if (j < MAX_LEN) expQ.push_back('{1'b0, frameBytes[i + 1 + j], 1'b0});
      end
      expQ.push_back('{1'b1, 8'h00, err});
   endtask

   task automatic buildFrame(input int preLen, input int payLen, input int erIdx, input bit randomPayload);
      frameBytes.delete();
      frameEr.delete();
      for (int i = 0; i < preLen; i++) begin
         frameBytes.push_back(8'h55);
         frameEr.push_back(1'b0);
      end
      frameBytes.push_back(8'hD5);
      frameEr.push_back(1'b0);
      for (int i = 1; i <= payLen; i++) begin
         frameBytes.push_back(randomPayload ? 8'($urandom) : 8'(i));
         frameEr.push_back(i == erIdx);
      end
   endtask

   task automatic sendFrame(input int gap);
      predictFrame();
      foreach (frameBytes[k]) applyStimulus(1'b1, frameEr[k], frameBytes[k]);
      firstGap = 1'b1;
      idleGap(gap);
      checkStatus();
   endtask

   initial begin : monitor
      logic [7:0] lastData;
      expT        e;
      lastData = 8'h00;
      forever begin
         @(negedge i_clk);
         if (i_reset) begin
            lastData = 8'h00;
         end else begin
            checkOutput("valid_eop_exclusive", {31'd0, o_valid & o_eop}, 32'd0);
            if (!o_valid) checkOutput("data_hold", {24'd0, o_data}, {24'd0, lastData});
            if (o_valid) begin
               if (expQ.size() == 0) begin
                  checks++;
                  fails++;
                  $display("[TB] FAIL unexpected_valid: got data %0h, expected no output", o_data);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("valid_data", {23'd0, 1'b0, o_data}, {23'd0, e.isEop, e.data});
               end
               lastData = o_data;
            end
            if (o_eop) begin
               if (expQ.size() == 0) begin
                  checks++;
                  fails++;
                  $display("[TB] FAIL unexpected_eop: got eop err=%0b, expected no output", o_err);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("eop_err", {30'd0, 1'b1, o_err}, {30'd0, e.isEop, e.err});
               end
            end
         end
      end
   end

   initial begin : stimulus
      #2;
      i_reset = 1'b1;
      #1;
      checkOutput("reset_outputs", {19'd0, o_valid, o_eop, o_err, o_data, o_link, o_speed, o_duplex}, 32'd0);
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      #1;
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;

      idleCycle(1'b0, 4'hD, 4'hD);
      idleCycle(1'b0, 4'hD, 4'hD);
      checkOutput("status_dd", {28'd0, o_link, o_speed, o_duplex}, {28'd0, 4'b1101});
      idleCycle(1'b0, 4'hD, 4'h5);
      checkOutput("status_hold_unequal", {28'd0, o_link, o_speed, o_duplex}, {28'd0, 4'b1101});
      idleCycle(1'b1, 4'h0, 4'h0);
      checkOutput("status_hold_carrier", {28'd0, o_link, o_speed, o_duplex}, {28'd0, 4'b1101});
      checkStatus();

      buildFrame(7, 60, 0, 1'b0);  sendFrame(3);
      buildFrame(7, 60, 10, 1'b0); sendFrame(3);

      frameBytes.delete();
      frameEr.delete();
      frameBytes = '{8'h55, 8'h55, 8'hAA};
      frameEr    = '{1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 20; i++) begin
         frameBytes.push_back(8'($urandom));
         frameEr.push_back(1'b0);
      end
      sendFrame(2);
      buildFrame(7, 60, 0, 1'b0); sendFrame(2);

      buildFrame(7, 0, 0, 1'b0);           sendFrame(2);
      buildFrame(7, MAX_LEN, 0, 1'b0);     sendFrame(2);
      buildFrame(7, MAX_LEN + 1, 0, 1'b0); sendFrame(2);
      buildFrame(7, MAX_LEN + 5, 0, 1'b0); sendFrame(2);
      buildFrame(2, 140, 0, 1'b1);         sendFrame(2);

      buildFrame(7, 10, 0, 1'b0); frameEr[3] = 1'b1; sendFrame(2);
      buildFrame(7, 10, 0, 1'b0); frameEr[7] = 1'b1; sendFrame(2);
      buildFrame(0, 12, 0, 1'b1); sendFrame(2);

      buildFrame(3, 5, 0, 1'b1); sendFrame(1);
      buildFrame(7, 8, 0, 1'b1); sendFrame(1);
      buildFrame(1, 3, 0, 1'b1); sendFrame(1);

      // Mid-frame reset: payload bytes 1..19 are seen, byte 20 never lands.
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'h55);
      applyStimulus(1'b1, 1'b0, 8'hD5);
      for (int b = 1; b <= 19; b++) begin
         expQ.push_back('{1'b0, 8'(b), 1'b0});
         applyStimulus(1'b1, 1'b0, 8'(b));
      end
      @(negedge i_clk);
      #1;
      i_reset = 1'b1;
      modelLink   = 1'b0;
      modelSpeed  = 2'b00;
      modelDuplex = 1'b0;
      firstGap    = 1'b0;
      #1;
      checkOutput("midframe_reset_outputs", {19'd0, o_valid, o_eop, o_err, o_data, o_link, o_speed, o_duplex}, 32'd0);
      checkOutput("midframe_reset_drained", expQ.size(), 32'd0);
      i_d0 = 4'h4;
      i_d1 = 4'h1;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      #1;
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;
      frameBytes.delete();
      frameEr.delete();
      for (int i = 0; i < 6; i++) begin
         frameBytes.push_back(8'h15 + 8'(i));
         frameEr.push_back(1'b0);
      end
      sendFrame(2);
      buildFrame(7, 60, 0, 1'b0); sendFrame(3);

      for (int f = 0; f < 40; f++) begin
         buildFrame($urandom_range(0, 8), $urandom_range(0, 110), 0, 1'b1);
         foreach (frameEr[k]) frameEr[k] = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 5) == 0) frameBytes[$urandom_range(0, 3) % frameBytes.size()] = 8'($urandom);
         sendFrame($urandom_range(1, 6));
      end

      for (int k = 0; k < 30 && expQ.size() != 0; k++) @(posedge i_clk);
      checkOutput("scoreboard_drained", expQ.size(), 32'd0);
      @(negedge i_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
